// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM state encoding and
// flag bit positions used by the LED mapping at the top level.
package alu_pkg;

  // Opcodes carried on sel
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  // Controller state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;

  // Flag bit positions (also the LED order)
  localparam int unsigned FLAG_CARRY    = 0;
  localparam int unsigned FLAG_ZERO     = 1;
  localparam int unsigned FLAG_EQUAL    = 2;
  localparam int unsigned FLAG_LESS     = 3;
  localparam int unsigned FLAG_GREATER  = 4;
  localparam int unsigned FLAG_OVERFLOW = 5;
  localparam int unsigned NUM_FLAGS     = 6;

endpackage : alu_pkg

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one partial product per cycle.
// The first partial product is folded into the start cycle so the full
// product is ready WIDTH-1 cycles after start, with a one-cycle done pulse.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (discards any work)
//   start         load a/b and begin (ignored while busy)
//   a, b          unsigned operands
//   busy          iteration in progress
//   done          one-cycle pulse, product valid from this cycle
//   product       2*WIDTH-bit unsigned product, held until next start
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // One shift-add step: add multiplicand to the high half if the current
  // multiplier LSB is set, then shift the whole accumulator right.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] s;
    s = (WIDTH+1)'(p[2*WIDTH-1:WIDTH]) + (p[0] ? (WIDTH+1)'(m) : (WIDTH+1)'(0));
    return {s, p[WIDTH-1:1]};
  endfunction

  // Next-state logic
  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (start && !busy_q) begin
      mcand_d = a;
      prod_d  = mul_step({WIDTH'(0), b}, a);
      cnt_d   = CW'(WIDTH - 1);
      busy_d  = 1'b1;
    end else if (busy_q) begin
      prod_d = mul_step(prod_q, mcand_q);
      cnt_d  = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule : alu_mul_seq

// File: rtl/alu_seq.sv
// Sequential WIDTH-bit ALU with valid/ready input handshake and registered
// result/flags. Single-cycle ops complete the cycle after acceptance; MUL runs
// on alu_mul_seq and completes WIDTH+1 cycles after acceptance.
// Optional build macro: ALU_SIGNED_EN (signed compares + overflow flag).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      operation handshake (ready only when idle)
//   a, b, sel                operands and opcode, captured on acceptance
//   out_valid                one-cycle pulse when result/flags update
//   result, result_hi        result word, MUL high word (0 otherwise)
//   carry_out, zero          carry/borrow/shift-out/MUL-high-nonzero, all-zero
//   equal, less_than, greater_than   compare of captured a and b
//   overflow                 signed overflow (0 unless ALU_SIGNED_EN)
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             zero,
  output logic             equal,
  output logic             less_than,
  output logic             greater_than,
  output logic             overflow
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]           state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]     result_q, result_d, hi_q, hi_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;

  logic                 accept_c, mul_start_c, mul_busy, mul_done;
  logic [2*WIDTH-1:0]   mul_product;

  logic [WIDTH:0]       sum_c, diff_c;
  logic [WIDTH-1:0]     alu_res_c;
  logic                 alu_carry_c, alu_ovf_c;
  logic [WIDTH-1:0]     res_lo_c, res_hi_c, cmp_a_c, cmp_b_c;
  logic                 res_carry_c, res_ovf_c;
  logic [NUM_FLAGS-1:0] new_flags_c;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_c),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign accept_c = in_valid && in_ready_q;

  // Single-cycle operations, evaluated on the live inputs at acceptance
  always_comb begin
    sum_c       = (WIDTH+1)'(a) + (WIDTH+1)'(b);
    diff_c      = (WIDTH+1)'(a) - (WIDTH+1)'(b);
    alu_res_c   = '0;
    alu_carry_c = 1'b0;
    alu_ovf_c   = 1'b0;
    case (sel)
      OP_ADD: begin
        alu_res_c   = sum_c[WIDTH-1:0];
        alu_carry_c = sum_c[WIDTH];
`ifdef ALU_SIGNED_EN
        alu_ovf_c   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
`endif
      end
      OP_SUB: begin
        alu_res_c   = diff_c[WIDTH-1:0];
        alu_carry_c = diff_c[WIDTH];  // borrow, i.e. a < b
`ifdef ALU_SIGNED_EN
        alu_ovf_c   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
`endif
      end
      OP_AND: alu_res_c = a & b;
      OP_OR:  alu_res_c = a | b;
      OP_XOR: alu_res_c = a ^ b;
      OP_SHL: begin
        // b == 0 passes a through; b >= WIDTH flushes everything out
        if (b == '0) begin
          alu_res_c = a;
        end else if (32'(b) < WIDTH) begin
          alu_res_c   = a << b;
          alu_carry_c = a[IW'(WIDTH - 32'(b))];
        end
      end
      OP_SHR: begin
        if (b == '0) begin
          alu_res_c = a;
        end else if (32'(b) < WIDTH) begin
          alu_res_c   = a >> b;
          alu_carry_c = a[IW'(32'(b) - 32'd1)];
        end
      end
      default: ;
    endcase
  end

  // Select result source and build the flag vector
  always_comb begin
    if (state_q == ST_MUL) begin
      res_lo_c    = mul_product[WIDTH-1:0];
      res_hi_c    = mul_product[2*WIDTH-1:WIDTH];
      res_carry_c = |res_hi_c;
`ifdef ALU_SIGNED_EN
      // unsigned product does not fit in WIDTH signed bits
      res_ovf_c   = (|res_hi_c) | res_lo_c[WIDTH-1];
`else
      res_ovf_c   = 1'b0;
`endif
      cmp_a_c     = a_q;
      cmp_b_c     = b_q;
    end else begin
      res_lo_c    = alu_res_c;
      res_hi_c    = '0;
      res_carry_c = alu_carry_c;
      res_ovf_c   = alu_ovf_c;
      cmp_a_c     = a;
      cmp_b_c     = b;
    end
    new_flags_c                = '0;
    new_flags_c[FLAG_CARRY]    = res_carry_c;
    new_flags_c[FLAG_ZERO]     = ~|{res_hi_c, res_lo_c};
    new_flags_c[FLAG_EQUAL]    = (cmp_a_c == cmp_b_c);
`ifdef ALU_SIGNED_EN
    new_flags_c[FLAG_LESS]     = ($signed(cmp_a_c) < $signed(cmp_b_c));
    new_flags_c[FLAG_GREATER]  = ($signed(cmp_a_c) > $signed(cmp_b_c));
`else
    new_flags_c[FLAG_LESS]     = (cmp_a_c < cmp_b_c);
    new_flags_c[FLAG_GREATER]  = (cmp_a_c > cmp_b_c);
`endif
    new_flags_c[FLAG_OVERFLOW] = res_ovf_c;
  end

  // Controller next-state and output-update logic
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    hi_d        = hi_q;
    flags_d     = flags_q;
    mul_start_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          a_d = a;
          b_d = b;
          if (sel == OP_MUL) begin
            state_d     = ST_MUL;
            mul_start_c = !mul_busy;
          end else begin
            state_d     = ST_EXEC;
            out_valid_d = 1'b1;
            result_d    = res_lo_c;
            hi_d        = res_hi_c;
            flags_d     = new_flags_c;
          end
        end
      end
      ST_EXEC: state_d = ST_IDLE;
      ST_MUL: begin
        // stay busy through the out_valid cycle, then release
        if (mul_done) begin
          out_valid_d = 1'b1;
          result_d    = res_lo_c;
          hi_d        = res_hi_c;
          flags_d     = new_flags_c;
        end else if (out_valid_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // Registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      hi_q        <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      flags_q     <= flags_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign result_hi    = hi_q;
  assign carry_out    = flags_q[FLAG_CARRY];
  assign zero         = flags_q[FLAG_ZERO];
  assign equal        = flags_q[FLAG_EQUAL];
  assign less_than    = flags_q[FLAG_LESS];
  assign greater_than = flags_q[FLAG_GREATER];
  assign overflow     = flags_q[FLAG_OVERFLOW];

endmodule : alu_seq

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed cases plus random ops
// against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [2:0]   sel;
  logic         out_valid;
  logic [W-1:0] result, result_hi;
  logic         carry_out, zero, equal, less_than, greater_than, overflow;

  int n_chk  = 0;
  int n_pass = 0;
  longint exp_prev_lo = 0;
  longint exp_prev_hi = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .sel          (sel),
    .out_valid    (out_valid),
    .result       (result),
    .result_hi    (result_hi),
    .carry_out    (carry_out),
    .zero         (zero),
    .equal        (equal),
    .less_than    (less_than),
    .greater_than (greater_than),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model straight from the opcode definitions
  task automatic model(input longint ma, input longint mb, input logic [2:0] ms,
                       output longint lo, output longint hi,
                       output bit c, output bit z, output bit e,
                       output bit l, output bit g, output bit o);
    longint m, half, sa, sb, sr, p;
    m    = longint'(1) << W;
    half = m / 2;
    sa   = (ma >= half) ? ma - m : ma;
    sb   = (mb >= half) ? mb - m : mb;
    lo = 0; hi = 0; c = 0; o = 0; sr = 0;
    case (ms)
      OP_ADD: begin lo = (ma + mb) % m; c = (ma + mb) >= m; sr = sa + sb; o = (sr >= half) || (sr < -half); end
      OP_SUB: begin lo = (ma - mb + m) % m; c = ma < mb; sr = sa - sb; o = (sr >= half) || (sr < -half); end
      OP_AND: lo = ma & mb;
      OP_OR:  lo = ma | mb;
      OP_XOR: lo = ma ^ mb;
      OP_SHL: begin
        if (mb == 0) lo = ma;
        else if (mb < W) begin lo = (ma << mb) % m; c = ((ma >> (W - mb)) & 1) != 0; end
      end
      OP_SHR: begin
        if (mb == 0) lo = ma;
        else if (mb < W) begin lo = ma >> mb; c = ((ma >> (mb - 1)) & 1) != 0; end
      end
      default: begin
        p = ma * mb; lo = p % m; hi = p / m; c = hi != 0; o = p >= half;
      end
    endcase
    z = (lo == 0) && (hi == 0);
    e = ma == mb;
`ifdef ALU_SIGNED_EN
    l = sa < sb; g = sa > sb;
`else
    l = ma < mb; g = ma > mb; o = 0;
`endif
  endtask

  // Issue one operation, check latency, busy/hold behaviour and outputs
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [2:0] ts, input bit poke);
    longint lo, hi; bit c, z, e, l, g, o; int lat, exp_lat;
    model(longint'(ta), longint'(tb_v), ts, lo, hi, c, z, e, l, g, o);
    exp_lat = (ts == OP_MUL) ? W + 1 : 1;
    chk("ready_before", in_ready, 1);
    a = ta; b = tb_v; sel = ts; in_valid = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      if (poke) begin a = W'($urandom); b = W'($urandom); sel = 3'($urandom); end
      else in_valid = 1'b0;
      chk("busy_not_ready", in_ready, 0);
      if (!out_valid) chk("result_hold", result, exp_prev_lo);
    end while (!out_valid && lat < 40);
    in_valid = 1'b0;
    chk("latency", lat, exp_lat);
    chk("result", result, lo);
    chk("result_hi", result_hi, hi);
    chk("carry_out", carry_out, c);
    chk("zero", zero, z);
    chk("equal", equal, e);
    chk("less_than", less_than, l);
    chk("greater_than", greater_than, g);
    chk("overflow", overflow, o);
    chk("one_hot_cmp", int'(equal) + int'(less_than) + int'(greater_than), 1);
    exp_prev_lo = lo; exp_prev_hi = hi;
    tick();
    chk("ov_pulse_end", out_valid, 0);
    chk("ready_after", in_ready, 1);
    chk("result_after", result, lo);
    chk("hi_after", result_hi, hi);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_result_hi"}, result_hi, 0);
    chk({tag, "_flags"}, {carry_out, zero, equal, less_than, greater_than, overflow}, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = '0;
    #12;
    chk_cleared("reset");
    tick();
    rst = 1'b0;
    tick();

    // Directed cases
    run_op(8'd200, 8'd100, OP_ADD, 0);
    run_op(8'd5,   8'd5,   OP_SUB, 0);
    run_op(8'd3,   8'd5,   OP_SUB, 0);
    run_op(8'd255, 8'd255, OP_MUL, 1);
    run_op(8'h81,  8'd1,   OP_SHL, 0);
    run_op(8'h81,  8'd1,   OP_SHR, 0);
    run_op(8'h81,  8'd9,   OP_SHL, 0);
    run_op(8'h81,  8'd8,   OP_SHR, 0);
    run_op(8'h5A,  8'd0,   OP_SHR, 0);
    run_op(8'h7F,  8'h01,  OP_ADD, 0);
    run_op(8'h80,  8'h01,  OP_AND, 0);
    run_op(8'h0F,  8'hF0,  OP_OR,  0);
    run_op(8'hAA,  8'hAA,  OP_XOR, 0);
    run_op(8'd0,   8'd77,  OP_MUL, 0);

    // Reset on the 4th busy cycle of a multiply
    chk("ready_before_rst", in_ready, 1);
    a = 8'd15; b = 8'd17; sel = OP_MUL; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk_cleared("midrst");
    tick();
    chk_cleared("midrst_hold");
    rst = 1'b0;
    exp_prev_lo = 0; exp_prev_hi = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("no_ov_after_rst", out_valid, 0);
    end
    run_op(8'd1, 8'd1, OP_ADD, 0);

    // Random operations
    for (int i = 0; i < 60; i++) begin
      logic [2:0] rs;
      logic [W-1:0] ra, rb;
      rs = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = (rs == OP_SHL || rs == OP_SHR) ? W'($urandom_range(0, 10)) : W'($urandom);
      if (i % 7 == 0) rb = ra;
      run_op(ra, rb, rs, (rs == OP_MUL) && (i % 2 == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_alu_seq
